// File: rtl/parity_pkg.sv
// Shared definitions for the odd-parity serial transmitter: FSM state
// encoding and the serial line levels used when framing a word.
package parity_pkg;

  // Frame sequencer states, fixed 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Serial line levels.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/odd_parity_gen.sv
// Combinational odd-parity generator: o_f is chosen so that the data bits
// plus o_f contain an odd number of ones.
module odd_parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  output logic              o_f
);

  assign o_f = ~^i_a;

endmodule

// File: rtl/odd_parity_tx_ctrl.sv
// Frames a parallel word as start / data (LSB first) / odd parity / stop
// and shifts it out on a single registered line, one bit every BIT_DIV
// clocks. A word is taken over a valid/ready handshake only while idle.
module odd_parity_tx_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BIT_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              parity_out,
  output logic              frame_done
);

  // Divider counts 0..BIT_DIV-1, bit index counts data bits; both >= 1 bit.
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int IDX_W = ($clog2(DATA_W + 1) > 1) ? $clog2(DATA_W + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  // Divider value one cycle before the end of a bit (only meaningful for BIT_DIV >= 2).
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'((BIT_DIV >= 2) ? (BIT_DIV - 2) : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_tx;
  logic                r_busy;
  logic                r_ready;
  logic                r_par;
  logic                r_done;

  logic                w_par;
  logic                w_accept;
  logic                w_bit_end;
  logic [DIV_W-1:0]    w_div_next;
  logic                w_done_next;

  // Parity of the incoming word, captured at the accept edge.
  odd_parity_gen #(
    .DATA_W (DATA_W)
  ) u_par_gen (
    .i_a (in_data),
    .o_f (w_par)
  );

  assign w_accept  = in_valid & r_ready;
  assign w_bit_end = (BIT_DIV == 1) ? 1'b1 : (r_div == DIV_LAST);

  // Next divider value: wraps at each bit boundary, held at 0 when idle or bypassed.
  always_comb begin
    w_div_next = '0;
    if ((r_state == ST_IDLE) || w_bit_end || (BIT_DIV == 1)) begin
      w_div_next = '0;
    end else begin
      w_div_next = r_div + 1'b1;
    end
  end

  // frame_done is registered, so it is raised one cycle early: on entry to
  // the single-cycle stop bit, or one cycle before the end of a longer one.
  always_comb begin
    w_done_next = 1'b0;
    case (r_state)
      ST_PARITY: begin
        if ((BIT_DIV == 1) && w_bit_end) begin
          w_done_next = 1'b1;
        end else begin
          w_done_next = 1'b0;
        end
      end
      ST_STOP: begin
        if ((BIT_DIV >= 2) && (r_div == DIV_PRE)) begin
          w_done_next = 1'b1;
        end else begin
          w_done_next = 1'b0;
        end
      end
      default: w_done_next = 1'b0;
    endcase
  end

  // Frame sequencer: state, divider, bit index, shifter and all outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= LINE_IDLE;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_par   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_div  <= '0;
          if (w_accept) begin
            r_shift <= in_data;
            r_par   <= w_par;
            r_idx   <= '0;
            r_tx    <= START_BIT;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= ST_START;
          end else begin
            r_tx    <= LINE_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end

        ST_START: begin
          r_div <= w_div_next;
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1'b1;
            r_idx   <= '0;
            r_state <= ST_DATA;
          end
        end

        ST_DATA: begin
          r_div <= w_div_next;
          if (w_bit_end) begin
            if (r_idx == IDX_LAST) begin
              r_tx    <= r_par;
              r_state <= ST_PARITY;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1'b1;
            end
          end
        end

        ST_PARITY: begin
          r_div  <= w_div_next;
          r_done <= w_done_next;
          if (w_bit_end) begin
            r_tx    <= STOP_BIT;
            r_state <= ST_STOP;
          end
        end

        ST_STOP: begin
          r_div  <= w_div_next;
          r_done <= w_done_next;
          if (w_bit_end) begin
            r_tx    <= LINE_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_div   <= '0;
          r_idx   <= '0;
          r_tx    <= LINE_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out     = r_tx;
  assign busy       = r_busy;
  assign in_ready   = r_ready;
  assign parity_out = r_par;
  assign frame_done = r_done;

endmodule

// File: tb/tb_odd_parity_tx_ctrl.sv
// Self-checking bench for odd_parity_tx_ctrl: a vector table of words with
// hand-computed parity, a per-cycle expected-output scoreboard filled when a
// word is accepted, plus handshake and mid-frame reset sequences.
module tb_odd_parity_tx_ctrl;

  localparam int DW = 8;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          tx_out;
  logic          busy;
  logic          parity_out;
  logic          frame_done;

  odd_parity_tx_ctrl #(
    .DATA_W  (DW),
    .BIT_DIV (BD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .parity_out (parity_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
  } vec_t;

  typedef struct {
    logic tx;
    logic bsy;
    logic rdy;
    logic fd;
    logic par;
  } exp_t;

  vec_t tbl[8];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   fd_seen = 0;
  logic model_par = 1'b0;
  logic cur_par = 1'b0;

  // Push the expected per-cycle outputs of one frame plus its trailing idle cycle.
  function automatic void push_frame(logic [DW-1:0] d, logic p);
    exp_t e;
    logic b;
    model_par = p;
    n_acc++;
    for (int s = 0; s < DW + 3; s++) begin
      if (s == 0) b = 1'b0;
      else if (s <= DW) b = d[s-1];
      else if (s == DW + 1) b = p;
      else b = 1'b1;
      for (int c = 0; c < BD; c++) begin
        e.tx = b; e.bsy = 1'b1; e.rdy = 1'b0; e.par = p;
        e.fd = ((s == DW + 2) && (c == BD - 1)) ? 1'b1 : 1'b0;
        exp_q.push_back(e);
      end
    end
    e.tx = 1'b1; e.bsy = 1'b0; e.rdy = 1'b1; e.fd = 1'b0; e.par = p;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if ({tx_out, busy, in_ready, frame_done, parity_out} !== {e.tx, e.bsy, e.rdy, e.fd, e.par}) begin
      n_err++;
      $display("FAIL %s t=%0t got tx/busy/rdy/done/par=%b%b%b%b%b want %b%b%b%b%b", name, $time,
               tx_out, busy, in_ready, frame_done, parity_out, e.tx, e.bsy, e.rdy, e.fd, e.par);
    end
  endtask

  // One clock: model accepts when its queue is empty, then compares outputs.
  task automatic tick(input string name);
    exp_t e;
    if (in_valid && (exp_q.size() == 0)) push_frame(in_data, cur_par);
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_seen++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
    end else begin
      e.tx = 1'b1; e.bsy = 1'b0; e.rdy = 1'b1; e.fd = 1'b0; e.par = model_par;
    end
    check(name, e);
  endtask

  // Run until the scoreboard empties, bounded.
  task automatic drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0) && (guard < 200)) begin
      tick(name);
      guard++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s drain timeout: %0d entries left, want 0", name, exp_q.size());
    end
  endtask

  task automatic send(input int idx);
    in_valid = 1'b1;
    in_data  = tbl[idx].data;
    cur_par  = tbl[idx].par;
    tick($sformatf("accept_%02h", tbl[idx].data));
    in_valid = 1'b0;
    fd_seen  = 0;
    drain($sformatf("frame_%02h", tbl[idx].data));
    n_vec++;
    if (fd_seen != 1) begin
      n_err++;
      $display("FAIL done_count_%02h got %0d want 1", tbl[idx].data, fd_seen);
    end
  endtask

  initial begin
    exp_t rst_e;
    tbl[0] = '{8'h00, 1'b1};
    tbl[1] = '{8'h07, 1'b0};
    tbl[2] = '{8'hFF, 1'b1};
    tbl[3] = '{8'h01, 1'b0};
    tbl[4] = '{8'h80, 1'b0};
    tbl[5] = '{8'hA5, 1'b1};
    tbl[6] = '{8'h3C, 1'b1};
    tbl[7] = '{8'h55, 1'b1};
    rst_e.tx = 1'b1; rst_e.bsy = 1'b0; rst_e.rdy = 1'b1; rst_e.fd = 1'b0; rst_e.par = 1'b0;

    // Reset for 3 cycles, then 20 idle cycles.
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", rst_e);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick("idle");

    // Table-driven frames.
    for (int i = 0; i < 5; i++) send(i);

    // Handshake: valid held; data changes mid-frame and is taken after the frame.
    in_valid = 1'b1; in_data = tbl[5].data; cur_par = tbl[5].par;
    n_acc = 0;
    tick("hs_accept_a5");
    for (int i = 0; i < 10; i++) tick("hs_a5");
    in_data = tbl[6].data; cur_par = tbl[6].par;
    for (int g = 0; (g < 200) && (n_acc < 2); g++) tick("hs_frames");
    in_valid = 1'b0;
    drain("hs_3c");
    n_vec++;
    if (n_acc != 2) begin
      n_err++;
      $display("FAIL hs_accepts got %0d want 2", n_acc);
    end

    // Mid-frame reset during data bit 3, then a clean 0x55 frame.
    in_valid = 1'b1; in_data = tbl[0].data; cur_par = tbl[0].par;
    tick("mr_accept");
    in_valid = 1'b0;
    for (int i = 0; i < BD + 3 * BD + 1; i++) tick("mr_pre");
    reset = 1'b1;
    #2;
    exp_q.delete();
    model_par = 1'b0;
    check("mr_async", rst_e);
    @(posedge clk);
    #1;
    check("mr_hold", rst_e);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick("mr_idle");
    send(7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
